// File: rtl/aurora_hls_crc_pkg.sv
// Shared definitions for the Aurora CRC measurement-window controller:
// FSM state encoding and default counter/timer widths.
package aurora_hls_crc_pkg;

    localparam int unsigned CNT_WIDTH_DEF   = 32;
    localparam int unsigned TIMER_WIDTH_DEF = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_RUN   = 2'd2,
        ST_LATCH = 2'd3
    } state_e;

endpackage

// File: rtl/aurora_hls_crc_sat_counter.sv
// Saturating up-counter with synchronous clear and increment enable.
// Holds at all-ones instead of wrapping.
module aurora_hls_crc_sat_counter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clr,
    input  logic             i_inc,
    output logic [WIDTH-1:0] o_count
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_inc && !(&r_count)) begin
            r_count <= r_count + ONE;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/aurora_hls_crc_window_ctrl.sv
// Clear / count / snapshot window controller over the Aurora CRC result stream.
// Publishes frame/error/cycle snapshots with a done pulse and a sticky threshold alarm.
module aurora_hls_crc_window_ctrl
    import aurora_hls_crc_pkg::*;
#(
    parameter int unsigned CNT_WIDTH   = CNT_WIDTH_DEF,
    parameter int unsigned TIMER_WIDTH = TIMER_WIDTH_DEF
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_start,
    input  logic                   i_stop,
    input  logic [TIMER_WIDTH-1:0] i_window_cycles,
    input  logic [CNT_WIDTH-1:0]   i_error_threshold,
    input  logic                   i_crc_valid,
    input  logic                   i_crc_pass_fail_n,
    output logic                   o_busy,
    output logic                   o_done,
    output logic [CNT_WIDTH-1:0]   o_frames_received,
    output logic [CNT_WIDTH-1:0]   o_frames_with_errors,
    output logic [TIMER_WIDTH-1:0] o_elapsed_cycles,
    output logic                   o_alarm
);

    localparam logic [TIMER_WIDTH-1:0] T_ZERO = '0;

    state_e                 r_state;
    logic [TIMER_WIDTH-1:0] r_window;
    logic [CNT_WIDTH-1:0]   r_threshold;
    logic                   r_busy;
    logic                   r_done;
    logic                   r_alarm;
    logic [CNT_WIDTH-1:0]   r_snap_rx;
    logic [CNT_WIDTH-1:0]   r_snap_err;
    logic [TIMER_WIDTH-1:0] r_snap_elapsed;

    logic                   w_clr;
    logic                   w_run;
    logic                   w_inc_rx;
    logic                   w_inc_err;
    logic [CNT_WIDTH-1:0]   w_rx_cnt;
    logic [CNT_WIDTH-1:0]   w_err_cnt;
    logic [TIMER_WIDTH-1:0] w_timer;
    logic [CNT_WIDTH-1:0]   w_rx_next;
    logic [CNT_WIDTH-1:0]   w_err_next;
    logic [TIMER_WIDTH-1:0] w_timer_next;
    logic                   w_timeout;
    logic                   w_end;
    logic                   w_alarm_hit;

    assign w_clr     = (r_state == ST_CLEAR);
    assign w_run     = (r_state == ST_RUN);
    assign w_inc_rx  = w_run && i_crc_valid;
    assign w_inc_err = w_inc_rx && !i_crc_pass_fail_n;

    aurora_hls_crc_sat_counter #(.WIDTH(CNT_WIDTH)) u_rx_cnt (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_clr   (w_clr),
        .i_inc   (w_inc_rx),
        .o_count (w_rx_cnt)
    );

    aurora_hls_crc_sat_counter #(.WIDTH(CNT_WIDTH)) u_err_cnt (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_clr   (w_clr),
        .i_inc   (w_inc_err),
        .o_count (w_err_cnt)
    );

    aurora_hls_crc_sat_counter #(.WIDTH(TIMER_WIDTH)) u_timer (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_clr   (w_clr),
        .i_inc   (w_run),
        .o_count (w_timer)
    );

    // Post-edge counter values, so the snapshot includes the final RUN cycle.
    assign w_rx_next    = w_rx_cnt + {{(CNT_WIDTH-1){1'b0}}, (w_inc_rx && !(&w_rx_cnt))};
    assign w_err_next   = w_err_cnt + {{(CNT_WIDTH-1){1'b0}}, (w_inc_err && !(&w_err_cnt))};
    assign w_timer_next = w_timer + {{(TIMER_WIDTH-1){1'b0}}, !(&w_timer)};

    assign w_timeout   = (r_window != T_ZERO) &&
                         (w_timer == r_window - {{(TIMER_WIDTH-1){1'b0}}, 1'b1});
    assign w_end       = w_run && (i_stop || w_timeout);
    assign w_alarm_hit = w_run && (r_threshold != '0) && (w_err_next >= r_threshold);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state        <= ST_IDLE;
            r_window       <= '0;
            r_threshold    <= '0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_alarm        <= 1'b0;
            r_snap_rx      <= '0;
            r_snap_err     <= '0;
            r_snap_elapsed <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_window    <= i_window_cycles;
                        r_threshold <= i_error_threshold;
                        r_alarm     <= 1'b0;
                        r_busy      <= 1'b1;
                        r_state     <= ST_CLEAR;
                    end
                end
                ST_CLEAR: r_state <= ST_RUN;
                ST_RUN: begin
                    if (w_alarm_hit) r_alarm <= 1'b1;
                    // Snapshot lands on the last RUN edge so it is visible with done in LATCH.
                    if (w_end) begin
                        r_snap_rx      <= w_rx_next;
                        r_snap_err     <= w_err_next;
                        r_snap_elapsed <= w_timer_next;
                        r_done         <= 1'b1;
                        r_state        <= ST_LATCH;
                    end
                end
                ST_LATCH: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_busy               = r_busy;
    assign o_done               = r_done;
    assign o_alarm              = r_alarm;
    assign o_frames_received    = r_snap_rx;
    assign o_frames_with_errors = r_snap_err;
    assign o_elapsed_cycles     = r_snap_elapsed;

endmodule

// File: tb/tb_aurora_hls_crc_window_ctrl.sv
// Bench for the CRC window controller: a 32-bit and a 4-bit counter instance share stimulus
// and are compared every cycle against a window-level model, plus literal spot checks.
module tb_aurora_hls_crc_window_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        valid = 1'b0;
    logic        pf = 1'b1;
    logic [31:0] win = '0;
    logic [31:0] thr = '0;

    logic        busy, done, alarm;
    logic [31:0] rx, err, el;
    logic        busy4, done4, alarm4;
    logic [3:0]  rx4, err4;
    logic [31:0] el4;

    always #5 clk = ~clk;

    aurora_hls_crc_window_ctrl #(.CNT_WIDTH(32), .TIMER_WIDTH(32)) u_dut (
        .i_clk                (clk),
        .i_rst                (rst),
        .i_start              (start),
        .i_stop               (stop),
        .i_window_cycles      (win),
        .i_error_threshold    (thr),
        .i_crc_valid          (valid),
        .i_crc_pass_fail_n    (pf),
        .o_busy               (busy),
        .o_done               (done),
        .o_frames_received    (rx),
        .o_frames_with_errors (err),
        .o_elapsed_cycles     (el),
        .o_alarm              (alarm)
    );

    aurora_hls_crc_window_ctrl #(.CNT_WIDTH(4), .TIMER_WIDTH(32)) u_dut4 (
        .i_clk                (clk),
        .i_rst                (rst),
        .i_start              (start),
        .i_stop               (stop),
        .i_window_cycles      (win),
        .i_error_threshold    (thr[3:0]),
        .i_crc_valid          (valid),
        .i_crc_pass_fail_n    (pf),
        .o_busy               (busy4),
        .o_done               (done4),
        .o_frames_received    (rx4),
        .o_frames_with_errors (err4),
        .o_elapsed_cycles     (el4),
        .o_alarm              (alarm4)
    );

    int n_chk  = 0;
    int n_fail = 0;
    int n_done = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic longint sat4(input longint v);
        return (v > 15) ? 15 : v;
    endfunction

    // Window-level model: phase 0 idle, 1 clear, 2 run, 3 latch; unbounded counts.
    int     m_phase = 0;
    longint m_win = 0, m_thr = 0, m_rx = 0, m_err = 0, m_len = 0;
    longint m_s_rx = 0, m_s_err = 0, m_s_len = 0;
    bit     m_done = 1'b0, m_alarm = 1'b0;

    always @(posedge clk) begin : model
        longint n_rx, n_err, n_len;
        if (rst) begin
            m_phase <= 0; m_win <= 0; m_thr <= 0;
            m_rx <= 0; m_err <= 0; m_len <= 0;
            m_s_rx <= 0; m_s_err <= 0; m_s_len <= 0;
            m_done <= 1'b0; m_alarm <= 1'b0;
        end else begin
            case (m_phase)
                0: begin
                    m_done <= 1'b0;
                    if (start) begin
                        m_win   <= longint'(win);
                        m_thr   <= longint'(thr);
                        m_alarm <= 1'b0;
                        m_phase <= 1;
                    end
                end
                1: begin
                    m_rx <= 0; m_err <= 0; m_len <= 0;
                    m_phase <= 2;
                end
                2: begin
                    n_len = m_len + 1;
                    n_rx  = m_rx + (valid ? 1 : 0);
                    n_err = m_err + ((valid && !pf) ? 1 : 0);
                    m_len <= n_len; m_rx <= n_rx; m_err <= n_err;
                    if (m_thr != 0 && n_err >= m_thr) m_alarm <= 1'b1;
                    if (stop || (m_win != 0 && n_len == m_win)) begin
                        m_s_rx <= n_rx; m_s_err <= n_err; m_s_len <= n_len;
                        m_done <= 1'b1;
                        m_phase <= 3;
                    end
                end
                default: begin
                    m_done <= 1'b0;
                    m_phase <= 0;
                end
            endcase
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            if (done) n_done++;
            chk("busy", busy, (m_phase != 0));
            chk("done", done, m_done);
            chk("alarm", alarm, m_alarm);
            chk("frames_received", rx, m_s_rx);
            chk("frames_with_errors", err, m_s_err);
            chk("elapsed_cycles", el, m_s_len);
            chk("busy4", busy4, (m_phase != 0));
            chk("done4", done4, m_done);
            chk("alarm4", alarm4, m_alarm);
            chk("frames_received4", rx4, sat4(m_s_rx));
            chk("frames_with_errors4", err4, sat4(m_s_err));
            chk("elapsed_cycles4", el4, m_s_len);
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    int d0;

    initial begin
        // Reset with traffic present
        valid = 1'b1; pf = 1'b0; start = 1'b1;
        tick(); chk_en = 1'b1;
        tick();
        chk("rst_busy", busy, 0); chk("rst_done", done, 0); chk("rst_alarm", alarm, 0);
        chk("rst_rx", rx, 0); chk("rst_err", err, 0); chk("rst_el", el, 0);
        rst = 1'b0; valid = 1'b0; pf = 1'b1; start = 1'b0;
        tick();

        // Basic 8-cycle window: 5 pass then 1 fail
        win = 8; thr = 0; start = 1'b1;
        tick(); start = 1'b0;
        d0 = n_done;
        for (int i = 0; i < 8; i++) begin
            tick();
            valid = (i < 6); pf = (i < 5);
            chk("basic_no_early_done", done, 0);
        end
        tick(); valid = 1'b0;
        chk("basic_done", done, 1); chk("basic_rx", rx, 6); chk("basic_err", err, 1);
        chk("basic_el", el, 8); chk("basic_alarm", alarm, 0);
        tick();
        chk("basic_done_once", n_done - d0, 1);

        // Unbounded window stopped after 4 RUN cycles, traffic in CLEAR and LATCH
        win = 0; valid = 1'b1; pf = 1'b1; start = 1'b1;
        tick(); start = 1'b0;
        tick(); tick(); tick();
        tick(); stop = 1'b1;
        tick(); stop = 1'b0;
        chk("stop_done", done, 1); chk("stop_rx", rx, 4); chk("stop_el", el, 4);
        tick(); valid = 1'b0;
        chk("stop_rx_hold", rx, 4);

        // Alarm at threshold 2 with fails on RUN cycles 2, 4, 6
        win = 10; thr = 2; start = 1'b1;
        tick(); start = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            valid = (i == 2 || i == 4 || i == 6); pf = 1'b0;
            if (i == 4) chk("alarm_before", alarm, 0);
            if (i == 5) chk("alarm_rise", alarm, 1);
        end
        tick(); valid = 1'b0; pf = 1'b1;
        chk("alarm_done", done, 1); chk("alarm_err", err, 3); chk("alarm_latch", alarm, 1);
        tick();
        chk("alarm_idle", alarm, 1);
        win = 3; thr = 0; start = 1'b1;
        tick(); start = 1'b0;
        chk("alarm_cleared", alarm, 0);
        chk("snapshot_held", err, 3);
        repeat (5) tick();

        // Saturation on the 4-bit instance
        win = 20; thr = 0; start = 1'b1;
        tick(); start = 1'b0; valid = 1'b1; pf = 1'b0;
        repeat (20) tick();
        tick(); valid = 1'b0; pf = 1'b1;
        chk("sat_rx4", rx4, 15); chk("sat_err4", err4, 15);
        chk("sat_rx32", rx, 20); chk("sat_el", el4, 20);
        tick();

        // Ignored requests, then reset mid-RUN
        win = 6; start = 1'b1;
        tick(); start = 1'b0;
        tick(); tick(); start = 1'b1;
        tick(); start = 1'b0;
        tick(); tick(); tick();
        tick();
        chk("ign_done", done, 1); chk("ign_el", el, 6);
        tick(); stop = 1'b1;
        tick(); stop = 1'b0;
        chk("ign_stop_idle", busy, 0);
        win = 5; start = 1'b1; stop = 1'b1;
        tick(); start = 1'b0; stop = 1'b0;
        chk("start_stop_busy", busy, 1);
        tick(); tick(); tick();
        d0 = n_done;
        rst = 1'b1;
        tick(); tick();
        chk("midrst_busy", busy, 0); chk("midrst_rx", rx, 0); chk("midrst_el", el, 0);
        rst = 1'b0;
        repeat (8) tick();
        chk("midrst_no_done", n_done - d0, 0);

        // Randomized traffic and requests
        for (int c = 0; c < 2000; c++) begin
            tick();
            start = ($urandom % 8) == 0;
            stop  = ($urandom % 12) == 0;
            valid = ($urandom % 2) == 0;
            pf    = ($urandom % 3) != 0;
            win   = $urandom_range(0, 20);
            thr   = $urandom_range(0, 6);
            rst   = ($urandom % 500) == 0;
        end
        start = 1'b0; stop = 1'b0; valid = 1'b0; rst = 1'b0;
        repeat (4) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/aurora_hls_crc_window_ctrl.md
Name: aurora_hls_crc_window_ctrl

Overview:
Measurement-window controller for the Aurora CRC statistics path.
- Sequences a clear / count / snapshot cycle over the CRC result stream (crc_valid, crc_pass_fail_n) from the Aurora core.
- Counts received and failing frames for a programmed number of cycles, or until the host stops it.
- Publishes a stable snapshot and raises a threshold alarm for the host-side HLS kernel.

Parameters:
- CNT_WIDTH, 32, width of the frame counters and of error_threshold.
- TIMER_WIDTH, 32, width of window_cycles and elapsed_cycles.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle request to begin a window; honoured only in IDLE.
- stop  in  1  single-cycle request to end the window early; honoured only in RUN.
- window_cycles  in  TIMER_WIDTH  window length in cycles; 0 = unbounded, ends only on stop; sampled on start.
- error_threshold  in  CNT_WIDTH  alarm threshold; 0 disables the alarm; sampled on start.
- crc_valid  in  1  CRC result strobe, one per frame.
- crc_pass_fail_n  in  1  1 = CRC pass, 0 = CRC fail; qualified by crc_valid.
- busy  out  1  high in CLEAR, RUN and LATCH.
- done  out  1  one-cycle pulse when the snapshot is updated.
- frames_received  out  CNT_WIDTH  snapshot count of valid frames.
- frames_with_errors  out  CNT_WIDTH  snapshot count of failing frames.
- elapsed_cycles  out  TIMER_WIDTH  snapshot of the number of RUN cycles.
- alarm  out  1  sticky; failing-frame count reached the threshold in the current or last window.

Behaviour:
- Reset (async, active-high):
  - State goes to IDLE.
  - All outputs, live counters, timer and latched parameters go to 0.
  - Reset mid-window abandons the window; no done is issued.
- States: IDLE, CLEAR, RUN, LATCH.
  - IDLE: start=1 latches window_cycles and error_threshold, clears alarm, and moves to CLEAR.
  - CLEAR: exactly 1 cycle; zeroes the live counters and the timer; moves to RUN.
  - RUN: counts events and increments the timer every cycle.
    - Ends on stop=1, or when window_cycles!=0 and timer==window_cycles-1.
    - If stop and timeout occur in the same cycle, the window ends once.
    - On ending, moves to LATCH.
  - LATCH: 1 cycle.
    - Copies the live counters and timer+1 into the snapshot outputs.
    - Asserts done.
    - Moves to IDLE.
- Event counting:
  - An event is counted only if crc_valid=1 on an edge while in RUN, including the final RUN cycle.
  - Events in IDLE, CLEAR or LATCH are dropped.
  - frames_received increments on crc_valid=1.
  - frames_with_errors increments on crc_valid=1 and crc_pass_fail_n=0.
  - crc_pass_fail_n is ignored when crc_valid=0.
- Arithmetic: live counters and the timer saturate at all-ones; there is no wrap-around.
- Latency:
  - If start is sampled at edge E0: CLEAR runs in cycle E0..E1 and RUN starts at E1.
  - For window N, RUN lasts exactly N cycles and elapsed_cycles = N.
  - done is high in the cycle following the last RUN cycle.
  - The snapshot becomes visible in the same cycle done is high.
- Snapshot outputs hold their value until the next LATCH; starting a new window does not disturb them.
- Alarm:
  - Armed only when the latched threshold != 0.
  - Set the cycle after the live error count becomes >= threshold during RUN.
  - Held through LATCH and IDLE; cleared only by the next accepted start or by reset.
- Ignored requests:
  - start outside IDLE is ignored.
  - stop outside RUN is ignored.
  - start and stop together in IDLE: start is accepted and stop is ignored.

Decomposition:
- Shared package aurora_hls_crc_pkg:
  - State encoding constants ST_IDLE, ST_CLEAR, ST_RUN, ST_LATCH.
  - Default widths CNT_WIDTH_DEF=32, TIMER_WIDTH_DEF=32.
- Sub-module aurora_hls_crc_sat_counter:
  - A CNT_WIDTH saturating counter with synchronous clear and increment-enable.
  - Instantiated for received frames, error frames and the timer (at TIMER_WIDTH).
- The FSM, parameter latches, snapshot registers and alarm stay in the top.

Test Plan:
1. Reset check: assert rst for 2 cycles with traffic present -> busy=0, done=0, alarm=0, all counts 0.
2. Basic window:
   - Stimulus: window_cycles=8, threshold=0, start; 5 pass frames then 1 fail frame, all inside RUN.
   - Required: done exactly once, in the 9th cycle after CLEAR; frames_received=6, frames_with_errors=1, elapsed_cycles=8, alarm=0.
3. Early stop and window boundaries:
   - Stimulus: window_cycles=0, start, crc_valid held high, stop after 3 RUN cycles.
   - Required: frames_received=4 (3 cycles plus the stop cycle), elapsed_cycles=4.
   - Frames presented during CLEAR and LATCH are not counted.
4. Alarm:
   - Stimulus: threshold=2, window_cycles=10, 3 fail frames.
   - Required: alarm rises 1 cycle after the 2nd fail and stays high after done.
   - A new start clears alarm to 0.
5. Saturation:
   - Stimulus: CNT_WIDTH=4, window_cycles=20, crc_valid=1 with crc_pass_fail_n=0 for all 20 RUN cycles.
   - Required: frames_received=15 and frames_with_errors=15, with no wrap.
6. Ignored requests and reset mid-run:
   - Stimulus: start during RUN; then stop in IDLE; then rst asserted mid-RUN.
   - Required: the start and stop have no effect on the window; rst returns the block to IDLE, done never pulses, and the snapshot reads 0.
